// File: rtl/clint.sv
// Core-local interrupt/trap controller: sequences mepc/mcause/mstatus writes
// for ecall, mret and timer interrupts. Optional macro: CLINT_VECTORED_EN.
module clint #(
    parameter logic [11:0] CSR_MSTATUS = 12'h300,
    parameter logic [11:0] CSR_MEPC    = 12'h341,
    parameter logic [11:0] CSR_MCAUSE  = 12'h342
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic [31:0] exception_i,
    input  logic [31:0] inst_addr_i,
    input  logic        irq_timer_i,
    input  logic        ex_jump_i,
    input  logic [31:0] mstatus_i,
    input  logic [31:0] mtvec_i,
    input  logic [31:0] mepc_i,
    output logic        csr_we_o,
    output logic [11:0] csr_waddr_o,
    output logic [31:0] csr_wdata_o,
    output logic        stallreq_o,
    output logic        jump_o,
    output logic [31:0] jump_addr_o
);

    typedef enum logic [2:0] {
        IDLE,
        W_MEPC,
        W_MCAUSE,
        W_MSTATUS,
        W_MRET,
        JUMP
    } state_e;

    localparam logic [31:0] CAUSE_ECALL = 32'd11;
    localparam logic [31:0] CAUSE_TIMER = 32'h8000_0007;

    state_e      state_q, state_d;
    logic [31:0] epc_q, epc_d;
    logic [31:0] cause_q, cause_d;
    logic [31:0] target_q, target_d;

    logic        trig_ecall;
    logic        trig_mret;
    logic        trig_irq;
    logic        trig_any;
    logic [31:0] trap_base;
    logic [31:0] irq_target;
    logic        unused_ok;

    assign trig_ecall = exception_i[1];
    assign trig_mret  = exception_i[0];
    assign trig_irq   = irq_timer_i & mstatus_i[3] & ~ex_jump_i;
    assign trig_any   = trig_ecall | trig_mret | trig_irq;
    assign trap_base  = {mtvec_i[31:2], 2'b00};

    // Interrupt target: base, or base + 4*cause in vectored mode
`ifdef CLINT_VECTORED_EN
    assign irq_target = (mtvec_i[1:0] == 2'b01)
                      ? trap_base + {CAUSE_TIMER[29:0], 2'b00}
                      : trap_base;
`else
    assign irq_target = trap_base;
`endif

    assign unused_ok = ^{exception_i[31:2], mtvec_i[1:0]};

    // Next-state and trap-context latching; triggers only matter in IDLE
    always_comb begin
        state_d  = state_q;
        epc_d    = epc_q;
        cause_d  = cause_q;
        target_d = target_q;
        unique case (state_q)
            IDLE: begin
                if (trig_ecall) begin
                    state_d  = W_MEPC;
                    epc_d    = inst_addr_i;
                    cause_d  = CAUSE_ECALL;
                    target_d = trap_base;
                end else if (trig_mret) begin
                    state_d  = W_MRET;
                    target_d = mepc_i;
                end else if (trig_irq) begin
                    state_d  = W_MEPC;
                    epc_d    = inst_addr_i;
                    cause_d  = CAUSE_TIMER;
                    target_d = irq_target;
                end
            end
            W_MEPC:    state_d = W_MCAUSE;
            W_MCAUSE:  state_d = W_MSTATUS;
            W_MSTATUS: state_d = JUMP;
            W_MRET:    state_d = JUMP;
            JUMP:      state_d = IDLE;
            default:   state_d = IDLE;
        endcase
    end

    // State and latched trap context
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q  <= IDLE;
            epc_q    <= '0;
            cause_q  <= '0;
            target_q <= '0;
        end else begin
            state_q  <= state_d;
            epc_q    <= epc_d;
            cause_q  <= cause_d;
            target_q <= target_d;
        end
    end

    // CSR write port and redirect decoded from the registered state
    always_comb begin
        csr_we_o    = 1'b0;
        csr_waddr_o = '0;
        csr_wdata_o = '0;
        jump_o      = 1'b0;
        jump_addr_o = '0;
        stallreq_o  = 1'b1;
        unique case (state_q)
            IDLE: stallreq_o = trig_any;
            W_MEPC: begin
                csr_we_o    = 1'b1;
                csr_waddr_o = CSR_MEPC;
                csr_wdata_o = epc_q;
            end
            W_MCAUSE: begin
                csr_we_o    = 1'b1;
                csr_waddr_o = CSR_MCAUSE;
                csr_wdata_o = cause_q;
            end
            W_MSTATUS: begin
                csr_we_o    = 1'b1;
                csr_waddr_o = CSR_MSTATUS;
                csr_wdata_o = {mstatus_i[31:8], mstatus_i[3],
                               mstatus_i[6:4], 1'b0, mstatus_i[2:0]};
            end
            W_MRET: begin
                csr_we_o    = 1'b1;
                csr_waddr_o = CSR_MSTATUS;
                csr_wdata_o = {mstatus_i[31:8], 1'b1,
                               mstatus_i[6:4], mstatus_i[7], mstatus_i[2:0]};
            end
            JUMP: begin
                jump_o      = 1'b1;
                jump_addr_o = target_q;
            end
            default: stallreq_o = 1'b0;
        endcase
    end

endmodule

// File: tb/tb_clint.sv
// Scoreboard bench for clint: expected CSR writes and jumps are queued by
// the stimulus and popped by a monitor whenever the DUT emits one.
module tb_clint;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic [31:0] exception_i;
    logic [31:0] inst_addr_i;
    logic        irq_timer_i;
    logic        ex_jump_i;
    logic [31:0] mstatus_i;
    logic [31:0] mtvec_i;
    logic [31:0] mepc_i;
    logic        csr_we_o;
    logic [11:0] csr_waddr_o;
    logic [31:0] csr_wdata_o;
    logic        stallreq_o;
    logic        jump_o;
    logic [31:0] jump_addr_o;

    typedef struct {
        int          cyc;
        bit          jmp;
        logic [11:0] addr;
        logic [31:0] data;
    } ev_t;

    ev_t exp_q[$];
    int  cyc = 0;
    int  errors = 0;
    int  checks = 0;

    clint dut (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .exception_i (exception_i),
        .inst_addr_i (inst_addr_i),
        .irq_timer_i (irq_timer_i),
        .ex_jump_i   (ex_jump_i),
        .mstatus_i   (mstatus_i),
        .mtvec_i     (mtvec_i),
        .mepc_i      (mepc_i),
        .csr_we_o    (csr_we_o),
        .csr_waddr_o (csr_waddr_o),
        .csr_wdata_o (csr_wdata_o),
        .stallreq_o  (stallreq_o),
        .jump_o      (jump_o),
        .jump_addr_o (jump_addr_o)
    );

    always #5 clk_i = ~clk_i;

    always @(posedge clk_i) cyc <= cyc + 1;

    // Monitor: every CSR write or jump must match the head of the queue
    always @(negedge clk_i) begin
        if (csr_we_o || jump_o) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected: cyc=%0d we=%0b addr=%h data=%h jump=%0b ja=%h",
                         cyc, csr_we_o, csr_waddr_o, csr_wdata_o, jump_o, jump_addr_o);
            end else begin
                ev_t e;
                logic ok;
                e = exp_q.pop_front();
                if (e.jmp)
                    ok = (cyc == e.cyc) && jump_o && !csr_we_o
                         && (jump_addr_o == e.data);
                else
                    ok = (cyc == e.cyc) && csr_we_o && !jump_o
                         && (csr_waddr_o == e.addr) && (csr_wdata_o == e.data);
                if (!ok) begin
                    errors++;
                    $display("FAIL event: got cyc=%0d we=%0b addr=%h data=%h jump=%0b ja=%h; want cyc=%0d jmp=%0b addr=%h data=%h",
                             cyc, csr_we_o, csr_waddr_o, csr_wdata_o, jump_o, jump_addr_o,
                             e.cyc, e.jmp, e.addr, e.data);
                end
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic push(input int c, input bit j, input logic [11:0] a,
                        input logic [31:0] d);
        ev_t e;
        e.cyc  = c;
        e.jmp  = j;
        e.addr = a;
        e.data = d;
        exp_q.push_back(e);
    endtask

    // Checks stall over n cycles starting in the current one
    task automatic stall_run(input string name, input int n, input bit v);
        for (int i = 0; i < n; i++) begin
            #1;
            chk(name, {31'd0, stallreq_o}, {31'd0, v});
            step();
        end
    endtask

    task automatic idle_outputs(input string name);
        chk({name, "_stall"}, {31'd0, stallreq_o}, 32'd0);
        chk({name, "_we"}, {31'd0, csr_we_o}, 32'd0);
        chk({name, "_jump"}, {31'd0, jump_o}, 32'd0);
        chk({name, "_wdata"}, csr_wdata_o, 32'd0);
        chk({name, "_jaddr"}, jump_addr_o, 32'd0);
    endtask

    int t;
    logic [31:0] irq_tgt;

    initial begin
        rst_i       = 1'b1;
        exception_i = '0;
        inst_addr_i = '0;
        irq_timer_i = 1'b0;
        ex_jump_i   = 1'b0;
        mstatus_i   = '0;
        mtvec_i     = 32'h100;
        mepc_i      = '0;
        step();
        step();
        rst_i = 1'b0;
        idle_outputs("reset");
        chk("reset_waddr", {20'd0, csr_waddr_o}, 32'd0);
        step();

        // ecall at PC 0x40
        mstatus_i   = 32'h8;
        inst_addr_i = 32'h40;
        exception_i = 32'h2;
        t = cyc;
        push(t + 1, 0, 12'h341, 32'h40);
        push(t + 2, 0, 12'h342, 32'd11);
        push(t + 3, 0, 12'h300, 32'h80);
        push(t + 4, 1, 12'h000, 32'h100);
        #1;
        chk("ecall_stall_T", {31'd0, stallreq_o}, 32'd1);
        step();
        exception_i = '0;
        stall_run("ecall_stall", 4, 1'b1);
        stall_run("ecall_after", 2, 1'b0);

        // mret with mepc 0x44
        mstatus_i   = 32'h80;
        mepc_i      = 32'h44;
        exception_i = 32'h1;
        t = cyc;
        push(t + 1, 0, 12'h300, 32'h88);
        push(t + 2, 1, 12'h000, 32'h44);
        #1;
        chk("mret_stall_T", {31'd0, stallreq_o}, 32'd1);
        step();
        exception_i = '0;
        stall_run("mret_stall", 2, 1'b1);
        stall_run("mret_after", 2, 1'b0);

        // timer interrupt, vectored mtvec
        mstatus_i   = 32'h8;
        mtvec_i     = 32'h101;
        inst_addr_i = 32'h80;
        irq_timer_i = 1'b1;
`ifdef CLINT_VECTORED_EN
        irq_tgt = 32'h11C;
`else
        irq_tgt = 32'h100;
`endif
        t = cyc;
        push(t + 1, 0, 12'h341, 32'h80);
        push(t + 2, 0, 12'h342, 32'h8000_0007);
        push(t + 3, 0, 12'h300, 32'h80);
        push(t + 4, 1, 12'h000, irq_tgt);
        #1;
        chk("irq_stall_T", {31'd0, stallreq_o}, 32'd1);
        step();
        irq_timer_i = 1'b0;
        stall_run("irq_stall", 4, 1'b1);
        stall_run("irq_after", 2, 1'b0);

        // irq masked by MIE=0
        mstatus_i   = 32'h0;
        irq_timer_i = 1'b1;
        stall_run("irq_masked", 3, 1'b0);

        // irq deferred during execute redirect
        mstatus_i = 32'h8;
        ex_jump_i = 1'b1;
        stall_run("irq_exjump", 3, 1'b0);
        irq_timer_i = 1'b0;
        ex_jump_i   = 1'b0;
        step();

        // ecall and irq together: ecall wins, base target
        inst_addr_i = 32'h60;
        exception_i = 32'h2;
        irq_timer_i = 1'b1;
        t = cyc;
        push(t + 1, 0, 12'h341, 32'h60);
        push(t + 2, 0, 12'h342, 32'd11);
        push(t + 3, 0, 12'h300, 32'h80);
        push(t + 4, 1, 12'h000, 32'h100);
        step();
        exception_i = '0;
        irq_timer_i = 1'b0;
        stall_run("both_stall", 4, 1'b1);
        stall_run("both_after", 2, 1'b0);

        // reset in the middle of an ecall trap
        inst_addr_i = 32'h40;
        exception_i = 32'h2;
        t = cyc;
        push(t + 1, 0, 12'h341, 32'h40);
        push(t + 2, 0, 12'h342, 32'd11);
        step();
        exception_i = '0;
        step();
        rst_i = 1'b1;
        step();
        rst_i = 1'b0;
        #1;
        idle_outputs("midrst");
        for (int i = 0; i < 8; i++) step();

        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL pending_events: got %0d left want 0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/clint.md
# clint

Core-local interrupt/trap controller for the five-stage RV32I pipeline. It consumes the `exception_o` vector from the decode stage (bit0 = mret, bit1 = ecall) and the external timer interrupt line. It sequences the machine-mode CSR updates (mepc, mcause, mstatus) through the CSR write port, then redirects fetch to the trap vector or to mepc. While a sequence is in progress it holds the pipeline through `stallreq_o`.

## Interface
Parameters:
- `CSR_MSTATUS`, 12'h300: mstatus address
- `CSR_MEPC`, 12'h341: mepc address
- `CSR_MCAUSE`, 12'h342: mcause address

Ports:
- `clk_i` in 1: clock
- `rst_i` in 1: reset (one clock; reset is synchronous and active-high)
- `exception_i` in 32: decode-stage exception vector; bit0 mret, bit1 ecall, others ignored
- `inst_addr_i` in 32: PC of the instruction currently in decode
- `irq_timer_i` in 1: level-sensitive timer interrupt request
- `ex_jump_i` in 1: execute stage is redirecting this cycle (decode PC invalid)
- `mstatus_i` in 32: current mstatus (bit3 MIE, bit7 MPIE)
- `mtvec_i` in 32: current mtvec
- `mepc_i` in 32: current mepc
- `csr_we_o` out 1: CSR write enable
- `csr_waddr_o` out 12: CSR write address
- `csr_wdata_o` out 32: CSR write data
- `stallreq_o` out 1: hold IF/ID/EX
- `jump_o` out 1: one-cycle fetch redirect plus IF/ID flush
- `jump_addr_o` out 32: redirect target

## Operation
- States: IDLE, W_MEPC, W_MCAUSE, W_MSTATUS, W_MRET, JUMP.
- Triggers are evaluated only in IDLE. Priority: ecall > mret > timer interrupt.
- **ecall** (exception_i[1]):
  - Latch epc = inst_addr_i, cause = 32'd11, target = {mtvec_i[31:2],2'b00}.
  - Sequence: W_MEPC → W_MCAUSE → W_MSTATUS → JUMP.
- **mret** (exception_i[0]):
  - Latch target = mepc_i.
  - Sequence: W_MRET → JUMP.
- **Interrupt**:
  - Taken when irq_timer_i && mstatus_i[3] && !ex_jump_i.
  - Latch epc = inst_addr_i (that instruction has not executed), cause = 32'h8000_0007.
  - Sequence is the same as ecall.
- CSR write data:
  - W_MEPC writes epc to `CSR_MEPC`.
  - W_MCAUSE writes cause to `CSR_MCAUSE`.
  - W_MSTATUS writes mstatus_i with bit7 = old bit3 and bit3 = 0.
  - W_MRET writes mstatus_i with bit3 = old bit7 and bit7 = 1.
- JUMP: jump_o=1, jump_addr_o=target; returns to IDLE at the next edge.
- Exceptions arriving in non-IDLE states are ignored. The decode instruction is frozen by the stall and flushed by jump_o, so it cannot retrigger.
- While a sequence is in progress, irq_timer_i stays pending (level). It is not retaken after a trap because MIE is then 0.

## Timing
- Reset: state=IDLE. csr_we_o=0, csr_waddr_o=0, csr_wdata_o=0, jump_o=0, jump_addr_o=0, stallreq_o=0; latched epc/cause/target cleared.
- stallreq_o:
  - Combinational: high in IDLE in a cycle where any trigger fires.
  - High in every non-IDLE state, including JUMP.
- CSR write and jump outputs are decoded from registered state. csr_we_o=0 outside the W_* states.
- Trap latency: trigger in cycle T; mepc write at T+1, mcause at T+2, mstatus at T+3; jump_o at T+4.
- mret latency: trigger at T; mstatus write at T+1; jump_o at T+2.
- Simultaneous ecall and irq: ecall is taken and the irq stays pending.
- irq with ex_jump_i=1: deferred, no stall that cycle.
- rst_i mid-sequence: IDLE and all outputs 0 at the next edge. CSR writes already issued are not undone; no jump is issued.

## Configuration
- `CLINT_VECTORED_EN` defined:
  - For interrupts with mtvec_i[1:0]==2'b01, target = {mtvec_i[31:2],2'b00} + 4*cause[30:0] (timer → base+0x1C).
  - ecall always uses base.
- Undefined: mtvec_i[1:0] is ignored and all traps go to base.

## Test plan
- ecall at PC 0x0000_0040, mtvec 0x0000_0100, mstatus 0x8:
  - Writes 0x341←0x40, 0x342←11, 0x300←0x80 on T+1..T+3.
  - jump_o at T+4 to 0x100; stallreq_o high T..T+4.
- mret with mepc 0x44, mstatus 0x80: 0x300←0x88 at T+1; jump to 0x44 at T+2.
- irq_timer_i=1, mstatus 0x8, PC 0x80:
  - mepc←0x80, mcause←0x8000_0007, jump to 0x100.
  - With `CLINT_VECTORED_EN` and mtvec 0x101: jump to 0x11C.
- irq_timer_i=1 with mstatus 0x0, or with ex_jump_i=1: no stall, no CSR write, no jump.
- ecall and irq in the same cycle: mcause←11.
- rst_i at T+2 of an ecall trap: outputs 0 at T+3; no jump ever issued.
